// File: rtl/sseg4_bcd_mux_pkg.sv
// Shared types and constants for the sseg4 display path: FSM states, clamp limit
// and active-low seven-segment codes ({g,f,e,d,c,b,a}).
package sseg4_pkg;

  typedef enum logic [1:0] {
    e_idle,
    e_req,
    e_wait
  } t_disp_state;

  localparam logic [13:0] BIN_MAX    = 14'd9999;
  localparam logic [6:0]  SSEG_BLANK = 7'h7F;
  localparam logic [6:0]  SSEG_DASH  = 7'h3F;

  localparam logic [6:0] SSEG_0 = 7'h40;
  localparam logic [6:0] SSEG_1 = 7'h79;
  localparam logic [6:0] SSEG_2 = 7'h24;
  localparam logic [6:0] SSEG_3 = 7'h30;
  localparam logic [6:0] SSEG_4 = 7'h19;
  localparam logic [6:0] SSEG_5 = 7'h12;
  localparam logic [6:0] SSEG_6 = 7'h02;
  localparam logic [6:0] SSEG_7 = 7'h78;
  localparam logic [6:0] SSEG_8 = 7'h00;
  localparam logic [6:0] SSEG_9 = 7'h10;

  function automatic logic [13:0] clamp_bin(input logic [13:0] bin);
    return (bin > BIN_MAX) ? BIN_MAX : bin;
  endfunction

endpackage

// File: rtl/sseg4_bcd_mux_bcd_to_sseg.sv
// Combinational BCD digit to active-low seven-segment decoder with blanking.
// Non-decimal codes render as a dash.
module bcd_to_sseg
  import sseg4_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SSEG_DASH;
    if (blank) begin
      seg = SSEG_BLANK;
    end else begin
      case (digit)
        4'd0:    seg = SSEG_0;
        4'd1:    seg = SSEG_1;
        4'd2:    seg = SSEG_2;
        4'd3:    seg = SSEG_3;
        4'd4:    seg = SSEG_4;
        4'd5:    seg = SSEG_5;
        4'd6:    seg = SSEG_6;
        4'd7:    seg = SSEG_7;
        4'd8:    seg = SSEG_8;
        4'd9:    seg = SSEG_9;
        default: seg = SSEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/sseg4_bcd_mux.sv
// Binary-to-display top: clamps incoming values, drives the bintobcd handshake and
// scans four common-anode digits. Define SSEG4_LZB_EN for leading-zero blanking.
module sseg4_bcd_mux
  import sseg4_pkg::*;
#(
  parameter int REFRESH_BITS = 18
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_bin_valid,
  input  logic [13:0] i_bin,
  input  logic [3:0]  i_dp,
  output logic        o_conv_start,
  output logic [13:0] o_conv_bin,
  input  logic        i_conv_ready,
  input  logic        i_conv_done,
  input  logic [3:0]  i_bcd3,
  input  logic [3:0]  i_bcd2,
  input  logic [3:0]  i_bcd1,
  input  logic [3:0]  i_bcd0,
  output logic        o_busy,
  output logic        o_ovf,
  output logic [3:0]  o_an,
  output logic [7:0]  o_sseg
);

  t_disp_state            state;
  logic [13:0]            conv_bin;
  logic                   conv_ovf;
  logic [13:0]            shadow_bin;
  logic                   shadow_ovf;
  logic                   pending;
  logic                   ovf;
  logic [3:0][3:0]        digits;
  logic [REFRESH_BITS-1:0] scan_cnt;
  logic [1:0]             sel;
  logic [13:0]            bin_clamped;
  logic                   bin_ovf;
  logic [3:0]             blank;
  logic [3:0][6:0]        seg_all;
  logic [3:0]             an;
  logic [7:0]             sseg;

  assign bin_ovf      = (i_bin > BIN_MAX);
  assign bin_clamped  = clamp_bin(i_bin);
  assign sel          = scan_cnt[REFRESH_BITS-1 -: 2];

  assign o_conv_start = (state == e_req);
  assign o_conv_bin   = conv_bin;
  assign o_busy       = (state != e_idle) | pending;
  assign o_ovf        = ovf;
  assign o_an         = an;
  assign o_sseg       = sseg;

  // o_conv_bin is only rewritten when leaving e_idle or e_wait, so bintobcd sees a stable operand.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= e_idle;
      conv_bin   <= '0;
      conv_ovf   <= 1'b0;
      shadow_bin <= '0;
      shadow_ovf <= 1'b0;
      pending    <= 1'b0;
      ovf        <= 1'b0;
      digits     <= '0;
    end else begin
      case (state)
        e_idle: begin
          if (i_bin_valid) begin
            conv_bin <= bin_clamped;
            conv_ovf <= bin_ovf;
            state    <= e_req;
          end
        end
        e_req: begin
          if (i_conv_ready) state <= e_wait;
          if (i_bin_valid) begin
            shadow_bin <= bin_clamped;
            shadow_ovf <= bin_ovf;
            pending    <= 1'b1;
          end
        end
        e_wait: begin
          if (i_conv_done) begin
            digits <= {i_bcd3, i_bcd2, i_bcd1, i_bcd0};
            ovf    <= conv_ovf;
            if (i_bin_valid) begin
              conv_bin <= bin_clamped;
              conv_ovf <= bin_ovf;
              pending  <= 1'b0;
              state    <= e_req;
            end else if (pending) begin
              conv_bin <= shadow_bin;
              conv_ovf <= shadow_ovf;
              pending  <= 1'b0;
              state    <= e_req;
            end else begin
              state <= e_idle;
            end
          end else if (i_bin_valid) begin
            shadow_bin <= bin_clamped;
            shadow_ovf <= bin_ovf;
            pending    <= 1'b1;
          end
        end
        default: state <= e_idle;
      endcase
    end
  end

`ifdef SSEG4_LZB_EN
  assign blank[3] = (digits[3] == 4'd0);
  assign blank[2] = blank[3] & (digits[2] == 4'd0);
  assign blank[1] = blank[2] & (digits[1] == 4'd0);
  assign blank[0] = 1'b0;
`else
  assign blank = 4'b0000;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dec
      bcd_to_sseg u_dec (
        .digit (digits[gi]),
        .blank (blank[gi]),
        .seg   (seg_all[gi])
      );
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scan_cnt <= '0;
      an       <= 4'hF;
      sseg     <= 8'hFF;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      an       <= ~(4'b0001 << sel);
      sseg     <= {~i_dp[sel], seg_all[sel]};
    end
  end

endmodule

// File: tb/tb_sseg4_bcd_mux.sv
// Directed bench for sseg4_bcd_mux with a behavioural bintobcd (15-cycle conversion).
// Expected segment codes are hand-computed; honours SSEG4_LZB_EN when defined.
module tb_sseg4_bcd_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bin_valid = 1'b0;
  logic [13:0] bin = '0;
  logic [3:0]  dp = 4'b0000;
  logic        conv_start;
  logic [13:0] conv_bin;
  logic        conv_ready = 1'b1;
  logic        conv_done = 1'b0;
  logic [3:0]  bcd3 = '0, bcd2 = '0, bcd1 = '0, bcd0 = '0;
  logic        busy, ovf;
  logic [3:0]  an;
  logic [7:0]  sseg;

  int          n_checks = 0;
  int          n_pass = 0;

  // bintobcd model state
  logic        model_busy = 1'b0;
  int          model_cnt = 0;
  int          model_op = 0;
  int          n_ops = 0;
  logic [13:0] op_log [0:31];

`ifdef SSEG4_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  always #5 clk = ~clk;

  sseg4_bcd_mux #(.REFRESH_BITS(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_bin_valid  (bin_valid),
    .i_bin        (bin),
    .i_dp         (dp),
    .o_conv_start (conv_start),
    .o_conv_bin   (conv_bin),
    .i_conv_ready (conv_ready),
    .i_conv_done  (conv_done),
    .i_bcd3       (bcd3),
    .i_bcd2       (bcd2),
    .i_bcd1       (bcd1),
    .i_bcd0       (bcd0),
    .o_busy       (busy),
    .o_ovf        (ovf),
    .o_an         (an),
    .o_sseg       (sseg)
  );

  // Independent of the DUT reset so a done pulse can arrive after the DUT was reset.
  always @(posedge clk) begin
    conv_done <= 1'b0;
    if (model_busy) begin
      if (model_cnt == 1) begin
        conv_done  <= 1'b1;
        bcd3       <= 4'((model_op / 1000) % 10);
        bcd2       <= 4'((model_op / 100) % 10);
        bcd1       <= 4'((model_op / 10) % 10);
        bcd0       <= 4'(model_op % 10);
        model_busy <= 1'b0;
      end
      model_cnt <= model_cnt - 1;
    end else if (conv_start && conv_ready) begin
      model_busy         <= 1'b1;
      model_cnt          <= 15;
      conv_ready         <= 1'b0;
      model_op           <= int'(conv_bin);
      op_log[n_ops % 32] <= conv_bin;
      n_ops              <= n_ops + 1;
    end else begin
      conv_ready <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else begin
      n_pass++;
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic pulse_bin(input logic [13:0] v);
    @(posedge clk); #1;
    bin       = v;
    bin_valid = 1'b1;
    @(posedge clk); #1;
    bin_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic check_digit(input string tag, input int idx, input logic [7:0] exp);
    logic [3:0] pat;
    pat = 4'b1111;
    pat[idx] = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (an == pat) break;
    end
    check({tag, "_an"}, 32'(an), 32'(pat));
    check(tag, 32'(sseg), 32'(exp));
  endtask

  initial begin
    int n0;
    logic [3:0] exp_an;

    // Reset state and scan order
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an), 32'hF);
    check("rst_sseg", 32'(sseg), 32'hFF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(conv_start), 32'd0);
    check("rst_conv_bin", 32'(conv_bin), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_sseg", 32'(sseg), 32'hC0);
    for (int k = 0; k < 4; k++) begin
      exp_an = 4'b1111;
      exp_an[k] = 1'b0;
      check($sformatf("scan_an%0d", k), 32'(an), 32'(exp_an));
      repeat (4) @(negedge clk);
    end

    // 1234: one handshake, digits 1,2,3,4
    n0 = n_ops;
    pulse_bin(14'd1234);
    @(negedge clk);
    check("req_start", 32'(conv_start), 32'd1);
    check("req_bin", 32'(conv_bin), 32'd1234);
    @(negedge clk);
    check("wait_start", 32'(conv_start), 32'd0);
    wait_idle("busy_1234");
    check("hs_1234", 32'(n_ops - n0), 32'd1);
    check("ovf_1234", 32'(ovf), 32'd0);
    check_digit("d3_1234", 3, 8'hF9);
    check_digit("d2_1234", 2, 8'hA4);
    check_digit("d1_1234", 1, 8'hB0);
    check_digit("d0_1234", 0, 8'h99);

    // Overflow clamp, then cleared by an in-range value
    pulse_bin(14'h3FFF);
    @(negedge clk);
    check("clamp_bin", 32'(conv_bin), 32'h270F);
    wait_idle("busy_ovf");
    check("ovf_set", 32'(ovf), 32'd1);
    for (int k = 0; k < 4; k++) check_digit($sformatf("d%0d_9999", k), k, 8'h90);
    pulse_bin(14'd5);
    wait_idle("busy_5");
    check("ovf_clr", 32'(ovf), 32'd0);

    // Latest pending value wins; operand stable during wait
    n0 = n_ops;
    pulse_bin(14'd100);
    repeat (3) @(negedge clk);
    pulse_bin(14'd200);
    pulse_bin(14'd300);
    @(negedge clk);
    check("hold_bin", 32'(conv_bin), 32'd100);
    check("hold_busy", 32'(busy), 32'd1);
    wait_idle("busy_pend");
    check("hs_pend", 32'(n_ops - n0), 32'd2);
    check("op_first", 32'(op_log[n0 % 32]), 32'd100);
    check("op_second", 32'(op_log[(n0 + 1) % 32]), 32'd300);
    check_digit("d3_300", 3, LZB ? 8'hFF : 8'hC0);
    check_digit("d2_300", 2, 8'hB0);
    check_digit("d1_300", 1, 8'hC0);
    check_digit("d0_300", 0, 8'hC0);

    // Value 7 with dp on digit 2
    dp = 4'b0100;
    pulse_bin(14'd7);
    wait_idle("busy_7");
    check_digit("d3_7", 3, LZB ? 8'hFF : 8'hC0);
    check_digit("d2_7", 2, LZB ? 8'h7F : 8'h40);
    check_digit("d1_7", 1, LZB ? 8'hFF : 8'hC0);
    check_digit("d0_7", 0, 8'hF8);
    dp = 4'b0000;

    // Reset during e_wait; late done must be ignored
    pulse_bin(14'd42);
    repeat (4) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_an", 32'(an), 32'hF);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (conv_done) break;
    end
    check("late_done_seen", 32'(conv_done), 32'd1);
    repeat (3) @(negedge clk);
    check("post_busy", 32'(busy), 32'd0);
    check("post_start", 32'(conv_start), 32'd0);
    check("post_conv_bin", 32'(conv_bin), 32'd0);
    check_digit("d0_post", 0, 8'hC0);
    check_digit("d3_post", 3, LZB ? 8'hFF : 8'hC0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
